// File: rtl/div_16.sv
// Signed 16-bit restoring divider: one shift-subtract step per cycle on operand
// magnitudes, with signs restored and the exception cases flagged at the end.
module div_16 #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    count_reg;
   logic [WIDTH:0]   rem_reg;
   logic [WIDTH-1:0] quo_reg;
   logic [WIDTH-1:0] divisor_reg;
   logic             sign_q_reg;
   logic             sign_r_reg;
   logic [WIDTH-1:0] result_reg;
   logic [WIDTH-1:0] remainder_reg;
   logic             exception_reg;

   logic             start;
   logic             last_step;
   logic             div_zero;
   logic             overflow;
   logic             exc;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   rem_step;
   logic [WIDTH-1:0] quo_step;

   // Magnitude of 0x8000 wraps back to 0x8000, which is correct read as unsigned.
   assign a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   assign div_zero  = (data_operandB == '0);
   assign overflow  = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
   assign exc       = div_zero || overflow;
   assign start     = (state_reg == IDLE) && ctrl_DIV;
   assign last_step = (count_reg == CW'(WIDTH-1));

   assign shifted  = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
   assign diff     = shifted - {1'b0, divisor_reg};
   assign rem_step = diff[WIDTH] ? shifted : diff;
   assign quo_step = {quo_reg[WIDTH-2:0], ~diff[WIDTH]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (ctrl_DIV) state_next = exc ? DONE : RUN;
         RUN:  if (last_step) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_reg     <= '0;
         rem_reg       <= '0;
         quo_reg       <= '0;
         divisor_reg   <= '0;
         sign_q_reg    <= 1'b0;
         sign_r_reg    <= 1'b0;
         result_reg    <= '0;
         remainder_reg <= '0;
         exception_reg <= 1'b0;
      end else if (start) begin
         count_reg     <= '0;
         rem_reg       <= '0;
         quo_reg       <= a_mag;
         divisor_reg   <= b_mag;
         sign_q_reg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         sign_r_reg    <= data_operandA[WIDTH-1];
         exception_reg <= exc;
         if (exc) begin
            result_reg    <= '0;
            remainder_reg <= '0;
         end
      end else if (state_reg == RUN) begin
         rem_reg   <= rem_step;
         quo_reg   <= quo_step;
         count_reg <= count_reg + CW'(1);
         // Final step: publish sign-restored outputs as DONE is entered.
         if (last_step) begin
            result_reg    <= sign_q_reg ? -quo_step : quo_step;
            remainder_reg <= sign_r_reg ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
         end
      end
   end

   assign data_result    = result_reg;
   assign data_remainder = remainder_reg;
   assign data_exception = exception_reg;
   assign data_resultRDY = (state_reg == DONE);
   assign busy           = (state_reg != IDLE);

endmodule
